// File: rtl/sine_sum_pkg.sv
// sine_sum_pkg: shared defaults and elaboration-time helpers for the
// sine_sum_multi DDS summer (sine table generator, output width, latency).
package sine_sum_pkg;

  localparam int  LUT_AW_DEF = 10;
  localparam int  SIN_W_DEF  = 12;
  localparam real PI         = 3.14159265358979323846;

  // Composite width: each adder-tree level adds one bit, so the sum cannot overflow.
  function automatic int sum_width(int sin_w, int num_ch);
    return sin_w + $clog2(num_ch);
  endfunction

  // Register stages from accumulator to sind_sum: acc, LUT, then one per tree level.
  function automatic int pipe_latency(int num_ch);
    return 2 + $clog2(num_ch);
  endfunction

  // One full-wave unsigned sine entry, offset binary, centred on 2^(sin_w-1)-0.5.
  // Rounding is half-up so entry 0 lands on 2^(sin_w-1).
  function automatic int sine_lut_value(int k, int lut_aw, int sin_w);
    real half;
    real x;
    half = real'(1 << (sin_w - 1)) - 0.5;
    x    = half + half * $sin(2.0 * PI * real'(k) / real'(1 << lut_aw));
    return int'($floor(x + 0.5));
  endfunction

endpackage

// File: rtl/sine_sum_multi_channel.sv
// sine_dds_channel: one DDS tone. Double-buffered phase increment (shadow ->
// active on commit), wrapping phase accumulator and a registered sine LUT.
// Optional feature: define SINE_SUM_DITHER_EN to add a per-channel 4-bit LFSR
// to the accumulator bits below the LUT address before truncation.
module sine_dds_channel
  import sine_sum_pkg::*;
#(
  parameter int DELTA_W = 12,
  parameter int ACC_W   = 16,
  parameter int LUT_AW  = LUT_AW_DEF,
  parameter int SIN_W   = SIN_W_DEF,
  parameter int CH_IDX  = 0
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               wr_i,
  input  logic [DELTA_W-1:0] delta_i,
  input  logic               commit_i,
  input  logic               phase_clr_i,
  input  logic               en_i,
  output logic [SIN_W-1:0]   sample_o
);

  localparam int FRAC_W    = ACC_W - LUT_AW;
  localparam int LUT_DEPTH = 1 << LUT_AW;

  logic [DELTA_W-1:0] shadow_q, shadow_d;
  logic [DELTA_W-1:0] active_q, active_d;
  logic [ACC_W-1:0]   acc_q, acc_d;
  logic [SIN_W-1:0]   lut_q, lut_d;
  logic [LUT_AW-1:0]  lut_addr;
  logic [SIN_W-1:0]   rom [LUT_DEPTH];

  // NOTE: the sine table is constant wiring resolved at elaboration, so it has no reset.
  for (genvar k = 0; k < LUT_DEPTH; k++) begin : g_rom
    localparam int VAL = sine_lut_value(k, LUT_AW, SIN_W);
    assign rom[k] = SIN_W'(VAL);
  end

`ifdef SINE_SUM_DITHER_EN
  // Place the 4-bit dither at the top of the fractional phase bits.
  localparam int DITH_L = (FRAC_W >= 4) ? FRAC_W - 4 : 0;
  localparam int DITH_R = (FRAC_W >= 4) ? 0 : 4 - FRAC_W;

  logic [3:0]       lfsr_q, lfsr_d;
  logic [ACC_W-1:0] acc_dith;

  // Step the x^4+x^3+1 LFSR and dither the read address, not the stored phase.
  always_comb begin
    lfsr_d   = {lfsr_q[2:0], lfsr_q[3] ^ lfsr_q[2]};
    acc_dith = acc_q + (ACC_W'(lfsr_q >> DITH_R) << DITH_L);
  end

  // LFSR state, seeded nonzero per channel.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) lfsr_q <= 4'((CH_IDX % 15) + 1);
    else      lfsr_q <= lfsr_d;
  end

  assign lut_addr = acc_dith[ACC_W-1 -: LUT_AW];
`else
  assign lut_addr = acc_q[ACC_W-1 -: LUT_AW];
`endif

  // Next-state for shadow/active deltas, accumulator and LUT sample.
  // NOTE: each output gets a value on every path (defaults first), so no latch is inferred.
  always_comb begin
    // A write in the commit cycle bypasses the shadow straight into the commit.
    shadow_d = wr_i ? delta_i : shadow_q;
    active_d = commit_i ? shadow_d : active_q;

    // The commit edge still advances with the old delta; clear overrides and
    // applies even to disabled channels.
    acc_d = acc_q;
    if (commit_i && phase_clr_i) acc_d = '0;
    else if (en_i)               acc_d = acc_q + ACC_W'(active_q);

    lut_d = en_i ? rom[lut_addr] : '0;
  end

  // Channel state registers.
  // NOTE: non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      shadow_q <= '0;
      active_q <= '0;
      acc_q    <= '0;
      lut_q    <= '0;
    end else begin
      shadow_q <= shadow_d;
      active_q <= active_d;
      acc_q    <= acc_d;
      lut_q    <= lut_d;
    end
  end

  assign sample_o = lut_q;

endmodule

// File: rtl/sine_sum_multi.sv
// sine_sum_multi: NUM_CH-channel DDS sine summer. Channels feed a registered
// binary adder tree whose root is the unsigned composite tone sind_sum.
// Optional feature macro: SINE_SUM_DITHER_EN (phase dither inside each channel).
module sine_sum_multi
  import sine_sum_pkg::*;
#(
  parameter int NUM_CH  = 4,
  parameter int DELTA_W = 12,
  parameter int ACC_W   = 16,
  parameter int LUT_AW  = LUT_AW_DEF,
  parameter int SIN_W   = SIN_W_DEF
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                cfg_wr,
  input  logic [$clog2(NUM_CH)-1:0]           cfg_ch,
  input  logic [DELTA_W-1:0]                  cfg_delta,
  input  logic                                cfg_commit,
  input  logic                                cfg_phase_clr,
  input  logic [NUM_CH-1:0]                   ch_en,
  output logic [sum_width(SIN_W, NUM_CH)-1:0] sind_sum,
  output logic                                sum_valid
);

  localparam int CH_W   = $clog2(NUM_CH);
  localparam int LEVELS = $clog2(NUM_CH);
  localparam int SUM_W  = sum_width(SIN_W, NUM_CH);
  localparam int LAT    = pipe_latency(NUM_CH);
  localparam int CNT_W  = $clog2(LAT + 1);

  logic [SIN_W-1:0] sample [NUM_CH];

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    sine_dds_channel #(
      .DELTA_W (DELTA_W),
      .ACC_W   (ACC_W),
      .LUT_AW  (LUT_AW),
      .SIN_W   (SIN_W),
      .CH_IDX  (i)
    ) u_ch (
      .clk         (clk),
      .rst         (rst),
      .wr_i        (cfg_wr && (cfg_ch == CH_W'(i))),
      .delta_i     (cfg_delta),
      .commit_i    (cfg_commit),
      .phase_clr_i (cfg_phase_clr),
      .en_i        (ch_en[i]),
      .sample_o    (sample[i])
    );
  end

  // Heap-indexed tree: node n has children 2n and 2n+1, root is node 1,
  // leaves NUM_CH..2*NUM_CH-1 are the registered channel samples.
  logic [SUM_W-1:0] node_v [1:2*NUM_CH-1];
  logic [SUM_W-1:0] node_d [1:NUM_CH-1];
  logic [SUM_W-1:0] node_q [1:NUM_CH-1];

  // A node at depth d holds SIN_W + (LEVELS - d) bits; upper bits are forced to 0.
  function automatic logic [SUM_W-1:0] node_mask(int n);
    int w;
    w = SIN_W + LEVELS - ($clog2(n + 1) - 1);
    return {SUM_W{1'b1}} >> (SUM_W - w);
  endfunction

  // Gather tree inputs: internal node registers followed by zero-extended leaves.
  always_comb begin
    for (int n = 1; n < NUM_CH; n++) node_v[n] = node_q[n];
    for (int j = 0; j < NUM_CH; j++) node_v[NUM_CH + j] = SUM_W'(sample[j]);
  end

  // Pairwise sums for every internal node, each one bit wider than its children.
  always_comb begin
    for (int n = 1; n < NUM_CH; n++) begin
      node_d[n] = (node_v[2*n] + node_v[2*n + 1]) & node_mask(n);
    end
  end

  // Adder-tree pipeline registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int n = 1; n < NUM_CH; n++) node_q[n] <= '0;
    end else begin
      for (int n = 1; n < NUM_CH; n++) node_q[n] <= node_d[n];
    end
  end

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             sum_valid_q, sum_valid_d;

  // Count edges after reset release; valid sets on the LAT-th edge and sticks.
  always_comb begin
    cnt_d       = cnt_q;
    sum_valid_d = sum_valid_q;
    if (!sum_valid_q) begin
      cnt_d = cnt_q + CNT_W'(1);
      if (cnt_q == CNT_W'(LAT - 1)) sum_valid_d = 1'b1;
    end
  end

  // Fill counter and valid flag registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q       <= '0;
      sum_valid_q <= 1'b0;
    end else begin
      cnt_q       <= cnt_d;
      sum_valid_q <= sum_valid_d;
    end
  end

  assign sind_sum  = node_q[1];
  assign sum_valid = sum_valid_q;

endmodule

// File: tb/tb_sine_sum_multi.sv
// tb_sine_sum_multi: scoreboard bench for sine_sum_multi (default parameters).
// A cycle model pushes the expected tree input every edge; a monitor pops the
// value due at sind_sum and compares. Scenario tasks add targeted checks.
module tb_sine_sum_multi;

  localparam int NUM_CH = 4;
  localparam int SUM_W  = 14;
  localparam int LAT    = 4;
  localparam int FRAC_W = 6;
  localparam int DEPTH  = 1024;

  logic              clk = 1'b0;
  logic              rst;
  logic              cfg_wr;
  logic [1:0]        cfg_ch;
  logic [11:0]       cfg_delta;
  logic              cfg_commit;
  logic              cfg_phase_clr;
  logic [NUM_CH-1:0] ch_en;
  logic [SUM_W-1:0]  sind_sum;
  logic              sum_valid;

  int checks = 0;
  int errors = 0;

  int          lut_tab [DEPTH];
  int unsigned m_shadow [NUM_CH];
  int unsigned m_active [NUM_CH];
  int unsigned m_acc    [NUM_CH];
  int          m_cyc;
  int          exp_q [$];

  always #5 clk = ~clk;

  sine_sum_multi dut (
    .clk           (clk),
    .rst           (rst),
    .cfg_wr        (cfg_wr),
    .cfg_ch        (cfg_ch),
    .cfg_delta     (cfg_delta),
    .cfg_commit    (cfg_commit),
    .cfg_phase_clr (cfg_phase_clr),
    .ch_en         (ch_en),
    .sind_sum      (sind_sum),
    .sum_valid     (sum_valid)
  );

  function automatic int ref_sine(int k);
    real x;
    x = 2047.5 + 2047.5 * $sin(2.0 * 3.14159265358979323846 * real'(k) / 1024.0);
    return int'($floor(x + 0.5));
  endfunction

  task automatic model_reset();
    for (int c = 0; c < NUM_CH; c++) begin
      m_shadow[c] = 0;
      m_active[c] = 0;
      m_acc[c]    = 0;
    end
    m_cyc = 0;
    exp_q.delete();
    exp_q.push_back(0);
    exp_q.push_back(0);
  endtask

  // Behaviour at one rising edge, using the inputs held stable across it.
  task automatic model_edge();
    int s;
    int unsigned sh_next;
    s = 0;
    for (int c = 0; c < NUM_CH; c++)
      if (ch_en[c]) s += lut_tab[m_acc[c] >> FRAC_W];
    for (int c = 0; c < NUM_CH; c++) begin
      sh_next = (cfg_wr && cfg_ch == 2'(c)) ? int'(cfg_delta) : m_shadow[c];
      if (cfg_commit && cfg_phase_clr) m_acc[c] = 0;
      else if (ch_en[c])               m_acc[c] = (m_acc[c] + m_active[c]) & 32'hFFFF;
      if (cfg_commit) m_active[c] = sh_next;
      m_shadow[c] = sh_next;
    end
    exp_q.push_back(s);
    m_cyc++;
  endtask

  // Scoreboard monitor: advance the model at each edge, compare 1 time unit later.
  always @(posedge clk) begin
    int  exp_s;
    logic exp_v;
    if (!rst) begin
      #1;
      checks++;
      if (sind_sum !== '0) begin
        errors++;
        $display("FAIL sb_reset_sum @%0t: sind_sum=%0d expected=0", $time, sind_sum);
      end
      checks++;
      if (sum_valid !== 1'b0) begin
        errors++;
        $display("FAIL sb_reset_valid @%0t: sum_valid=%b expected=0", $time, sum_valid);
      end
    end else begin
      model_edge();
      exp_s = exp_q.pop_front();
      exp_v = (m_cyc >= LAT);
      #1;
      checks++;
      if (sind_sum !== SUM_W'(exp_s)) begin
        errors++;
        $display("FAIL sb_sum @%0t: sind_sum=%0d expected=%0d", $time, sind_sum, exp_s);
      end
      checks++;
      if (sum_valid !== exp_v) begin
        errors++;
        $display("FAIL sb_valid @%0t: sum_valid=%b expected=%b", $time, sum_valid, exp_v);
      end
    end
  end

  // Stimulus helpers: called at a negedge, return at the negedge after the edge.
  task automatic drive_write(int ch, int delta);
    cfg_wr = 1'b1; cfg_ch = 2'(ch); cfg_delta = 12'(delta);
    @(negedge clk);
    cfg_wr = 1'b0;
  endtask

  task automatic drive_commit(bit clr);
    cfg_commit = 1'b1; cfg_phase_clr = clr;
    @(negedge clk);
    cfg_commit = 1'b0; cfg_phase_clr = 1'b0;
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    checks++;
    if (sind_sum !== '0 || sum_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_state: sind_sum=%0d sum_valid=%b expected 0/0", sind_sum, sum_valid);
    end
    model_reset();
    rst = 1'b1;
    for (int i = 1; i <= LAT; i++) begin
      @(negedge clk);
      checks++;
      if (sum_valid !== (i == LAT)) begin
        errors++;
        $display("FAIL reset_valid_rise edge %0d: sum_valid=%b expected=%b", i, sum_valid, i == LAT);
      end
    end
    checks++;
    if (sind_sum !== 14'd8192) begin
      errors++;
      $display("FAIL reset_sum: sind_sum=%0d expected=8192", sind_sum);
    end
  endtask

  task automatic test_single_tone();
    int v [0:1100];
    int first_chg, vmax, vmin;
    ch_en = 4'h1;
    repeat (6) @(negedge clk);
    drive_write(0, 64);
    drive_commit(1'b0);
    for (int i = 1; i <= 1100; i++) begin
      @(negedge clk);
      v[i] = sind_sum;
    end
    first_chg = -1; vmax = 0; vmin = 1 << 20;
    for (int i = 1; i <= 1100; i++) begin
      if (first_chg < 0 && v[i] != 2048) first_chg = i;
      if (v[i] > vmax) vmax = v[i];
      if (v[i] < vmin) vmin = v[i];
    end
    checks++;
    if (first_chg !== 4) begin
      errors++;
      $display("FAIL tone_latency: first new sample at commit+%0d expected commit+4", first_chg);
    end
    checks++;
    if (v[4] !== lut_tab[1]) begin
      errors++;
      $display("FAIL tone_first: sind_sum=%0d expected=%0d", v[4], lut_tab[1]);
    end
    checks++;
    if (v[4 + 1024] !== lut_tab[1]) begin
      errors++;
      $display("FAIL tone_period: sind_sum=%0d expected=%0d", v[4 + 1024], lut_tab[1]);
    end
    checks++;
    if (vmax !== 4095 || vmin !== 0) begin
      errors++;
      $display("FAIL tone_peak_trough: max=%0d min=%0d expected 4095/0", vmax, vmin);
    end
  endtask

  task automatic test_phase_clr();
    int v [0:520];
    int vmax, vmin;
    ch_en = 4'h3;
    drive_write(1, 200);
    drive_commit(1'b0);
    repeat (40) @(negedge clk);
    drive_write(0, 128);
    drive_write(1, 128);
    drive_commit(1'b1);
    for (int i = 1; i <= 520; i++) begin
      @(negedge clk);
      v[i] = sind_sum;
    end
    vmax = 0; vmin = 1 << 20;
    for (int i = 3; i <= 520; i++) begin
      if (v[i] > vmax) vmax = v[i];
      if (v[i] < vmin) vmin = v[i];
    end
    checks++;
    if (v[3] !== 4096) begin
      errors++;
      $display("FAIL clr_first: sind_sum=%0d expected=4096", v[3]);
    end
    checks++;
    if (v[131] !== 8190) begin
      errors++;
      $display("FAIL clr_peak_time: sind_sum=%0d expected=8190", v[131]);
    end
    checks++;
    if (vmax !== 8190 || vmin !== 0) begin
      errors++;
      $display("FAIL clr_range: max=%0d min=%0d expected 8190/0", vmax, vmin);
    end
  endtask

  task automatic test_same_cycle_commit();
    int v [0:6];
    int exp_v [0:6];
    ch_en = 4'h2;
    drive_write(1, 77);
    repeat (8) @(negedge clk);
    cfg_wr = 1'b1; cfg_ch = 2'd1; cfg_delta = 12'd300;
    cfg_commit = 1'b1; cfg_phase_clr = 1'b1;
    @(negedge clk);
    cfg_wr = 1'b0; cfg_commit = 1'b0; cfg_phase_clr = 1'b0;
    for (int i = 1; i <= 6; i++) begin
      @(negedge clk);
      v[i] = sind_sum;
    end
    exp_v[3] = lut_tab[0]; exp_v[4] = lut_tab[4];
    exp_v[5] = lut_tab[9]; exp_v[6] = lut_tab[14];
    for (int i = 3; i <= 6; i++) begin
      checks++;
      if (v[i] !== exp_v[i]) begin
        errors++;
        $display("FAIL bypass_commit step %0d: sind_sum=%0d expected=%0d", i, v[i], exp_v[i]);
      end
    end
  endtask

  task automatic test_enable_gap();
    drive_write(2, 100);
    ch_en = 4'h4;
    drive_commit(1'b0);
    repeat (10) @(negedge clk);
    ch_en = 4'h0;
    for (int j = 1; j <= 10; j++) begin
      @(negedge clk);
      if (j >= 3) begin
        checks++;
        if (sind_sum !== '0) begin
          errors++;
          $display("FAIL gap_zero step %0d: sind_sum=%0d expected=0", j, sind_sum);
        end
      end
    end
    ch_en = 4'h4;
    repeat (12) @(negedge clk);
  endtask

  task automatic test_async_reset();
    @(negedge clk);
    #2;
    rst = 1'b0;
    model_reset();
    #1;
    checks++;
    if (sind_sum !== '0 || sum_valid !== 1'b0) begin
      errors++;
      $display("FAIL async_reset: sind_sum=%0d sum_valid=%b expected 0/0", sind_sum, sum_valid);
    end
    repeat (2) @(negedge clk);
    rst = 1'b1;
    for (int i = 1; i <= LAT; i++) begin
      @(negedge clk);
      checks++;
      if (sum_valid !== (i == LAT)) begin
        errors++;
        $display("FAIL rerelease_valid edge %0d: sum_valid=%b expected=%b", i, sum_valid, i == LAT);
      end
    end
  endtask

  task automatic test_wrap();
    int v3, v4, vend, vmax, vmin;
    ch_en = 4'h1;
    cfg_wr = 1'b1; cfg_ch = 2'd0; cfg_delta = 12'd4095;
    cfg_commit = 1'b1; cfg_phase_clr = 1'b1;
    @(negedge clk);
    cfg_wr = 1'b0; cfg_commit = 1'b0; cfg_phase_clr = 1'b0;
    v3 = 0; v4 = 0; vend = 0; vmax = 0; vmin = 1 << 20;
    for (int i = 1; i <= 65536 + 4; i++) begin
      @(negedge clk);
      if (i == 3) v3 = sind_sum;
      if (i == 4) v4 = sind_sum;
      if (i == 65536 + 4) vend = sind_sum;
      if (i >= 3) begin
        if (int'(sind_sum) > vmax) vmax = sind_sum;
        if (int'(sind_sum) < vmin) vmin = sind_sum;
      end
    end
    checks++;
    if (v3 !== lut_tab[0] || v4 !== lut_tab[63]) begin
      errors++;
      $display("FAIL wrap_start: got %0d,%0d expected %0d,%0d", v3, v4, lut_tab[0], lut_tab[63]);
    end
    checks++;
    if (vend !== lut_tab[63]) begin
      errors++;
      $display("FAIL wrap_return: sind_sum=%0d expected=%0d", vend, lut_tab[63]);
    end
    checks++;
    if (vmax !== 4095 || vmin !== 0) begin
      errors++;
      $display("FAIL wrap_range: max=%0d min=%0d expected 4095/0", vmax, vmin);
    end
  endtask

  initial begin
    #1_500_000;
    $display("FAIL watchdog: simulation exceeded its time budget");
    $fatal(1, "watchdog expired");
  end

  initial begin
    for (int k = 0; k < DEPTH; k++) lut_tab[k] = ref_sine(k);
    model_reset();
    rst = 1'b0;
    cfg_wr = 1'b0; cfg_ch = '0; cfg_delta = '0;
    cfg_commit = 1'b0; cfg_phase_clr = 1'b0;
    ch_en = 4'hF;

    test_reset();
    test_single_tone();
    test_phase_clr();
    test_same_cycle_commit();
    test_enable_gap();
    test_async_reset();
    test_wrap();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
